apb_master: RTL and testbench
=============================

# apb_master

APB requester that converts a simple single-outstanding command interface into APB3 transfers, with wait states, `PSLVERR` and a bounded-wait timeout. It sits between a local controller (CPU bridge, test sequencer, DMA) and the team's APB slaves. Every transfer is a full SETUP→ACCESS sequence. Exactly one response is returned per accepted command.

## Interface
Parameters:
- ADDR_WIDTH, 8, width of `cmd_addr` and `PADDR`.
- DATA_WIDTH, 32, width of all data buses.
- TIMEOUT, 16, maximum ACCESS cycles before abort; 0 disables the timeout.

Ports:
- PCLK  in  1  APB clock; all logic on its rising edge.
- PRESETn  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE; a command is accepted when `cmd_valid && cmd_ready`.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  transfer address.
- cmd_wdata  in  DATA_WIDTH  write data.
- rsp_valid  out  1  one-cycle completion pulse; no backpressure.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and for timeouts.
- rsp_err  out  1  slave error or timeout; valid with `rsp_valid`.
- rsp_timeout  out  1  transfer aborted by timeout; valid with `rsp_valid`.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PADDR  out  ADDR_WIDTH  APB address.
- PWDATA  out  DATA_WIDTH  APB write data.
- PRDATA  in  DATA_WIDTH  APB read data.
- PREADY  in  1  slave ready; extends ACCESS while low.
- PSLVERR  in  1  slave error; sampled only when `PREADY` is high in ACCESS.

## Operation
- FSM states and transitions:
  - IDLE→SETUP on command accept.
  - SETUP→ACCESS unconditionally.
  - ACCESS→IDLE on `PREADY=1` or on timeout.
- All APB outputs and `rsp_*` outputs are registered. `cmd_ready` is decoded from the state register (`state==IDLE`).
- On accept, `cmd_write`, `cmd_addr` and `cmd_wdata` are latched into `PWRITE`, `PADDR` and `PWDATA`. These hold stable through SETUP and ACCESS. After completion they keep their last values until the next accept.
- SETUP: `PSEL=1`, `PENABLE=0`.
- ACCESS: `PSEL=1`, `PENABLE=1`.
- IDLE: `PSEL=0`, `PENABLE=0`.
- Normal completion (ACCESS with `PREADY=1`):
  - `rsp_valid=1` in the next cycle.
  - `rsp_err=PSLVERR`, `rsp_timeout=0`.
  - `rsp_rdata=PRDATA` for reads (captured even when `PSLVERR=1`); 0 for writes.
- Wait counter, width `$clog2(TIMEOUT+1)`:
  - Cleared on SETUP→ACCESS.
  - Incremented on each ACCESS cycle with `PREADY=0`.
- Timeout: if `TIMEOUT>0`, the counter equals `TIMEOUT-1` and `PREADY=0`, then at that edge the FSM goes to IDLE, `PSEL` and `PENABLE` drop, and next cycle `rsp_valid=1`, `rsp_err=1`, `rsp_timeout=1`, `rsp_rdata=0`. ACCESS therefore lasts at most TIMEOUT cycles.
- `PREADY=1` on the same cycle the timeout would fire wins: normal completion.
- `cmd_valid` while not IDLE is ignored (`cmd_ready=0`). Command inputs are don't-care when not accepted.
- `PREADY` and `PSLVERR` are ignored outside ACCESS.

## Timing
- Reset values (asynchronous on `PRESETn` low):
  - State IDLE, counter 0.
  - `PSEL`, `PENABLE`, `PWRITE`, `PADDR`, `PWDATA` all 0.
  - `rsp_valid`, `rsp_rdata`, `rsp_err`, `rsp_timeout` all 0.
  - `cmd_ready=1` once the state is IDLE.
- Reset mid-transfer aborts immediately: `PSEL` and `PENABLE` go low asynchronously, and no response is issued for the aborted command.
- Accept at edge k:
  - Cycle k+1: SETUP.
  - Cycle k+2: ACCESS.
  - `PREADY=1` sampled at the end of k+2 → cycle k+3: `rsp_valid=1`, IDLE, `cmd_ready=1`.
- Zero-wait throughput: 1 transfer per 3 cycles. A new command can be accepted in the same cycle `rsp_valid` is high.
- N wait states add N cycles: `rsp_valid` appears at k+3+N.
- Timeout: `rsp_valid` appears at k+2+TIMEOUT.
- `rsp_valid` is exactly one cycle wide, and there is exactly one response per accept.

## Test plan
- Zero-wait slave (`PREADY` tied 1, 16×32 memory on `PADDR[3:0]`): write 0xDEADBEEF to 0x03, then read 0x03 → write response `rsp_err=0`, `rsp_rdata=0`; read response `rsp_rdata=0xDEADBEEF`; each response 3 cycles after accept; `PSEL`/`PENABLE` sequence 10→11→00.
- `PREADY` low for 2 ACCESS cycles on a read of 0x05 (slave returns 0x12345678) → ACCESS lasts 3 cycles; `PADDR`/`PWRITE` stable throughout; `rsp_valid` at k+5 with 0x12345678.
- `PSLVERR=1` with `PREADY=1` on a write to 0x0F → `rsp_err=1`, `rsp_timeout=0`, single `rsp_valid` pulse.
- `TIMEOUT=16`, `PREADY` held 0 → `PENABLE` high exactly 16 cycles; then `rsp_err=1`, `rsp_timeout=1`, `rsp_rdata=0`; the next command completes normally once `PREADY` is restored.
- `cmd_valid` held high for 4 back-to-back writes (0x0→0x3, data = addr+1) → one accept per 3 cycles, 4 responses in order; readback returns 1, 2, 3, 4.
- `PRESETn` pulsed low during ACCESS with `PREADY=0` → all outputs 0 asynchronously, no `rsp_valid`; after release `cmd_ready=1` and a read of 0x00 returns 0 (slave also reset).

Source files
------------

// File: rtl/apb_master.sv
// APB3 requester: turns a single-outstanding command/response handshake into
// SETUP/ACCESS transfers, with wait states, slave errors and a bounded ACCESS wait.
module apb_master #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    // command side
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    // response side
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    // APB side
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    // A zero TIMEOUT still needs a one-bit counter so the declarations stay legal.
    localparam int                CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit                TO_EN   = (TIMEOUT > 0);
    localparam logic [CNT_W-1:0]  TO_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_wait_cnt;
    logic             w_timeout;

    assign cmd_ready = (r_state == ST_IDLE);

    // PREADY wins over an expiring counter: timeout only fires while the slave still stalls.
    assign w_timeout = TO_EN && !PREADY && (r_wait_cnt == TO_LAST);

    // Transfer sequencer with registered APB and response outputs.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state     <= ST_IDLE;
            r_wait_cnt  <= '0;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PADDR       <= '0;
            PWDATA      <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    PENABLE <= 1'b0;
                    if (cmd_valid) begin
                        r_state <= ST_SETUP;
                        PSEL    <= 1'b1;
                        PWRITE  <= cmd_write;
                        PADDR   <= cmd_addr;
                        PWDATA  <= cmd_wdata;
                    end else begin
                        PSEL    <= 1'b0;
                    end
                end
                ST_SETUP: begin
                    r_state    <= ST_ACCESS;
                    r_wait_cnt <= '0;
                    PSEL       <= 1'b1;
                    PENABLE    <= 1'b1;
                end
                ST_ACCESS: begin
                    if (PREADY) begin
                        r_state     <= ST_IDLE;
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= PSLVERR;
                        rsp_timeout <= 1'b0;
                        rsp_rdata   <= PWRITE ? '0 : PRDATA;
                    end else if (w_timeout) begin
                        r_state     <= ST_IDLE;
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_rdata   <= '0;
                    end else begin
                        r_wait_cnt  <= r_wait_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    PSEL    <= 1'b0;
                    PENABLE <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master with a 16x32 memory slave whose PREADY/PSLVERR
// are steered per transfer.
module tb_apb_master;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [7:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [7:0]  PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    logic        tb_pready;
    logic        tb_slverr;
    logic [31:0] mem [16];

    int n_tests = 0;
    int n_fail  = 0;

    apb_master #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .TIMEOUT(16)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    assign PREADY  = tb_pready;
    assign PSLVERR = tb_slverr;
    assign PRDATA  = mem[PADDR[3:0]];

    // Memory slave, cleared by the same reset as the requester.
    always @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'd0;
        end else if (PSEL && PENABLE && PREADY && PWRITE) begin
            mem[PADDR[3:0]] <= PWDATA;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=no_finish expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issues one command at the current negedge and follows it to its response.
    task automatic xfer(input string tag, input logic w, input logic [7:0] a,
                        input logic [31:0] d, input int nwait, input logic slv,
                        input logic hold, input logic [31:0] exp_rdata,
                        input logic exp_err, input logic exp_to, input int exp_lat);
        int lat;
        int acc;
        bit got;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_valid = 1'b1;
        tb_slverr = slv;
        tb_pready = (nwait == 0);
        chk1({tag, "_ready"}, cmd_ready, 1'b1);
        @(posedge PCLK);
        lat = 0;
        acc = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            @(negedge PCLK);
            lat++;
            if (!hold) cmd_valid = 1'b0;
            if (rsp_valid) begin
                got = 1'b1;
            end else begin
                chk1({tag, "_psel"}, PSEL, 1'b1);
                chk1({tag, "_penable"}, PENABLE, (lat > 1));
                chk1({tag, "_pwrite"}, PWRITE, w);
                chk32({tag, "_paddr"}, {24'd0, PADDR}, {24'd0, a});
                if (w) chk32({tag, "_pwdata"}, PWDATA, d);
                chk1({tag, "_busy"}, cmd_ready, 1'b0);
                if (PENABLE) begin
                    acc++;
                    tb_pready = (acc > nwait);
                end
            end
        end
        chk1({tag, "_done"}, got, 1'b1);
        chk32({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk32({tag, "_access_cycles"}, 32'(acc), 32'(exp_lat - 2));
        chk32({tag, "_rdata"}, rsp_rdata, exp_rdata);
        chk1({tag, "_err"}, rsp_err, exp_err);
        chk1({tag, "_to"}, rsp_timeout, exp_to);
        chk1({tag, "_psel_idle"}, PSEL, 1'b0);
        chk1({tag, "_penable_idle"}, PENABLE, 1'b0);
        tb_pready = 1'b1;
        tb_slverr = 1'b0;
    endtask

    initial begin
        PRESETn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 8'd0;
        cmd_wdata = 32'd0;
        tb_pready = 1'b1;
        tb_slverr = 1'b0;
        repeat (3) @(negedge PCLK);
        PRESETn = 1'b1;
        @(negedge PCLK);

        chk1("rst_psel", PSEL, 1'b0);
        chk1("rst_penable", PENABLE, 1'b0);
        chk1("rst_pwrite", PWRITE, 1'b0);
        chk32("rst_paddr", {24'd0, PADDR}, 32'd0);
        chk32("rst_pwdata", PWDATA, 32'd0);
        chk1("rst_rsp_valid", rsp_valid, 1'b0);
        chk32("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk1("rst_rsp_err", rsp_err, 1'b0);
        chk1("rst_rsp_to", rsp_timeout, 1'b0);
        chk1("rst_cmd_ready", cmd_ready, 1'b1);

        // zero-wait write then read back
        xfer("wr03", 1'b1, 8'h03, 32'hDEADBEEF, 0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 3);
        xfer("rd03", 1'b0, 8'h03, 32'd0, 0, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 3);

        // two wait states on a read
        xfer("wr05", 1'b1, 8'h05, 32'h12345678, 0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 3);
        xfer("rd05w2", 1'b0, 8'h05, 32'd0, 2, 1'b0, 1'b0, 32'h12345678, 1'b0, 1'b0, 5);

        // slave error on a write, then single-pulse check
        xfer("wr0f_err", 1'b1, 8'h0F, 32'hA5A5A5A5, 0, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 3);
        @(negedge PCLK);
        chk1("err_pulse_width", rsp_valid, 1'b0);

        // timeout, then a normal read once PREADY is back
        xfer("rd05_to", 1'b0, 8'h05, 32'd0, 100, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 18);
        @(negedge PCLK);
        chk1("to_pulse_width", rsp_valid, 1'b0);
        xfer("rd05_after_to", 1'b0, 8'h05, 32'd0, 0, 1'b0, 1'b0, 32'h12345678, 1'b0, 1'b0, 3);

        // back-to-back writes with cmd_valid held high
        for (int i = 0; i < 4; i++) begin
            xfer("b2b_wr", 1'b1, 8'(i), 32'(i + 1), 0, 1'b0, (i < 3), 32'd0, 1'b0, 1'b0, 3);
        end
        for (int i = 0; i < 4; i++) begin
            xfer("b2b_rd", 1'b0, 8'(i), 32'd0, 0, 1'b0, 1'b0, 32'(i + 1), 1'b0, 1'b0, 3);
        end

        // reset during a stalled ACCESS
        @(negedge PCLK);
        cmd_write = 1'b0;
        cmd_addr  = 8'h01;
        cmd_valid = 1'b1;
        tb_pready = 1'b0;
        @(posedge PCLK);
        @(negedge PCLK);
        cmd_valid = 1'b0;
        @(negedge PCLK);
        chk1("mid_access_penable", PENABLE, 1'b1);
        @(negedge PCLK);
        #1 PRESETn = 1'b0;
        #1;
        chk1("async_psel", PSEL, 1'b0);
        chk1("async_penable", PENABLE, 1'b0);
        chk32("async_paddr", {24'd0, PADDR}, 32'd0);
        chk1("async_rsp_valid", rsp_valid, 1'b0);
        chk1("async_cmd_ready", cmd_ready, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge PCLK);
            chk1("in_rst_rsp_valid", rsp_valid, 1'b0);
        end
        PRESETn   = 1'b1;
        tb_pready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge PCLK);
            chk1("post_rst_rsp_valid", rsp_valid, 1'b0);
            chk1("post_rst_cmd_ready", cmd_ready, 1'b1);
        end
        xfer("rd00_post_rst", 1'b0, 8'h00, 32'd0, 0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
